// File: rtl/irq_arbiter_11.sv
// Eleven-source interrupt arbiter with edge-detected pending bits, a runtime
// enable mask and round-robin IDLE/REQ/SERVICE grant handshake to the CPU.
module irq_arbiter_11 #(
  parameter logic [10:0] InvertMask = 11'h000
) (
  input  logic        Clock_i,
  input  logic        Reset_i,
  input  logic [10:0] Req_i,
  input  logic        Cfg_We_i,
  input  logic [10:0] Cfg_Data_i,
  input  logic        Ack_i,
  input  logic        Eoi_i,
  output logic        Irq_o,
  output logic [3:0]  Irq_Id_o,
  output logic        Busy_o,
  output logic [10:0] Pending_o,
  output logic        Any_Pending_o
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

  state_e      state_q;
  logic        irq_q;
  logic [3:0]  irqId_q;
  logic        busy_q;
  logic [3:0]  ptr_q;
  logic [3:0]  winner_q;
  logic [10:0] hist_q;
  logic [10:0] pending_q;
  logic [10:0] pending_d;
  logic [10:0] enable_q;

  logic [10:0] reqAdj;
  logic [10:0] rise;
  logic [10:0] masked;
  logic [10:0] clrMask;
  logic        ackFire;
  logic        hiFound;
  logic [3:0]  hiIdx;
  logic [3:0]  loIdx;
  logic [3:0]  winIdx;

  assign reqAdj  = Req_i ^ InvertMask;
  assign rise    = reqAdj & ~hist_q;
  assign masked  = pending_q & enable_q;
  assign ackFire = (state_q == REQ) && Ack_i;
  assign clrMask = ackFire ? (11'b1 << winner_q) : 11'b0;
  // A new edge in the same cycle as the clear must survive, so set wins.
  assign pending_d = (pending_q & ~clrMask) | rise;

  // Round-robin: lowest enabled pending index at or above ptr, else lowest overall.
  always_comb begin
    hiFound = 1'b0;
    hiIdx   = 4'd0;
    loIdx   = 4'd0;
    for (int i = 10; i >= 0; i--) begin
      if (masked[i]) begin
        loIdx = 4'(i);
        if (i >= int'(ptr_q)) begin
          hiFound = 1'b1;
          hiIdx   = 4'(i);
        end
      end
    end
    winIdx = hiFound ? hiIdx : loIdx;
  end

  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) begin
      hist_q    <= 11'h000;
      pending_q <= 11'h000;
      enable_q  <= 11'h000;
    end else begin
      hist_q    <= reqAdj;
      pending_q <= pending_d;
      if (Cfg_We_i) enable_q <= Cfg_Data_i;
    end
  end

  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q  <= IDLE;
      irq_q    <= 1'b0;
      irqId_q  <= 4'd0;
      busy_q   <= 1'b0;
      ptr_q    <= 4'd0;
      winner_q <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|masked) begin
            state_q  <= REQ;
            irq_q    <= 1'b1;
            irqId_q  <= winIdx + 4'd1;
            winner_q <= winIdx;
          end
        end
        REQ: begin
          if (Ack_i) begin
            state_q <= SERVICE;
            irq_q   <= 1'b0;
            busy_q  <= 1'b1;
          end else if (Cfg_We_i && !Cfg_Data_i[winner_q]) begin
            // Winner masked off before acceptance: withdraw, keep it pending.
            state_q <= IDLE;
            irq_q   <= 1'b0;
            irqId_q <= 4'd0;
          end
        end
        SERVICE: begin
          if (Eoi_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            irqId_q <= 4'd0;
            ptr_q   <= (winner_q == 4'd10) ? 4'd0 : winner_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Irq_o         = irq_q;
  assign Irq_Id_o      = irqId_q;
  assign Busy_o        = busy_q;
  assign Pending_o     = pending_q;
  assign Any_Pending_o = |masked;

endmodule

// File: tb/tb_irq_arbiter_11.sv
// Directed bench for irq_arbiter_11: grant handshake, round-robin wrap,
// masking, same-cycle corner cases, polarity inversion and async reset.
module tb_irq_arbiter_11;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] req = 11'h000;
  logic [10:0] reqInv = 11'h001;
  logic        cfgWe = 1'b0;
  logic [10:0] cfgData = 11'h000;
  logic        ack = 1'b0;
  logic        eoi = 1'b0;

  logic        irq, busy, anyP;
  logic [3:0]  irqId;
  logic [10:0] pend;
  logic        irqI, busyI, anyPI;
  logic [3:0]  irqIdI;
  logic [10:0] pendI;

  int checkCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  irq_arbiter_11 dut (
    .Clock_i(clk), .Reset_i(reset), .Req_i(req), .Cfg_We_i(cfgWe),
    .Cfg_Data_i(cfgData), .Ack_i(ack), .Eoi_i(eoi), .Irq_o(irq),
    .Irq_Id_o(irqId), .Busy_o(busy), .Pending_o(pend), .Any_Pending_o(anyP)
  );

  irq_arbiter_11 #(.InvertMask(11'h001)) dutInv (
    .Clock_i(clk), .Reset_i(reset), .Req_i(reqInv), .Cfg_We_i(cfgWe),
    .Cfg_Data_i(cfgData), .Ack_i(ack), .Eoi_i(eoi), .Irq_o(irqI),
    .Irq_Id_o(irqIdI), .Busy_o(busyI), .Pending_o(pendI), .Any_Pending_o(anyPI)
  );

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    req = 11'h000; ack = 1'b0; eoi = 1'b0; cfgWe = 1'b0; cfgData = 11'h000;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic writeMask(input logic [10:0] m);
    cfgWe = 1'b1; cfgData = m;
    step();
    cfgWe = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checkCount++; if (irq !== 1'b0) begin failCount++; $display("[TB] FAIL reset_irq: got %0b expected 0", irq); end
    checkCount++; if (irqId !== 4'd0) begin failCount++; $display("[TB] FAIL reset_id: got %0d expected 0", irqId); end
    checkCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    checkCount++; if (pend !== 11'h000) begin failCount++; $display("[TB] FAIL reset_pend: got %h expected 000", pend); end
    checkCount++; if (anyP !== 1'b0) begin failCount++; $display("[TB] FAIL reset_any: got %0b expected 0", anyP); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_basic();
    doReset();
    writeMask(11'h7FF);
    req = 11'h008;
    step();
    checkCount++; if (pend !== 11'h008) begin failCount++; $display("[TB] FAIL basic_pend: got %h expected 008", pend); end
    checkCount++; if (irq !== 1'b0) begin failCount++; $display("[TB] FAIL basic_irq_early: got %0b expected 0", irq); end
    req = 11'h000;
    step();
    checkCount++; if (irq !== 1'b1) begin failCount++; $display("[TB] FAIL basic_irq: got %0b expected 1", irq); end
    checkCount++; if (irqId !== 4'd4) begin failCount++; $display("[TB] FAIL basic_id: got %0d expected 4", irqId); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    checkCount++; if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL basic_busy: got %0b expected 1", busy); end
    checkCount++; if (pend !== 11'h000) begin failCount++; $display("[TB] FAIL basic_pend_clr: got %h expected 000", pend); end
    checkCount++; if (irqId !== 4'd4) begin failCount++; $display("[TB] FAIL basic_id_held: got %0d expected 4", irqId); end
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    checkCount++; if (irqId !== 4'd0) begin failCount++; $display("[TB] FAIL basic_eoi_id: got %0d expected 0", irqId); end
    checkCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL basic_eoi_busy: got %0b expected 0", busy); end
    // Ptr is now 4: sources 2 and 5 together must grant 5 (id 6).
    req = 11'h024;
    step();
    req = 11'h000;
    step();
    checkCount++; if (irqId !== 4'd6) begin failCount++; $display("[TB] FAIL basic_ptr4: got %0d expected 6", irqId); end
  endtask

  task automatic test_wrap();
    doReset();
    writeMask(11'h7FF);
    req = 11'h401;
    step();
    req = 11'h000;
    checkCount++; if (pend !== 11'h401) begin failCount++; $display("[TB] FAIL wrap_pend: got %h expected 401", pend); end
    step();
    checkCount++; if (irqId !== 4'd1) begin failCount++; $display("[TB] FAIL wrap_first: got %0d expected 1", irqId); end
    ack = 1'b1; step(); ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
    checkCount++; if (irq !== 1'b0) begin failCount++; $display("[TB] FAIL wrap_idle_irq: got %0b expected 0", irq); end
    step();
    checkCount++; if (irqId !== 4'd11) begin failCount++; $display("[TB] FAIL wrap_second: got %0d expected 11", irqId); end
    ack = 1'b1; step(); ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
    // Ptr wrapped to 0: sources 1 and 5 must grant 1 (id 2).
    req = 11'h022;
    step();
    req = 11'h000;
    step();
    checkCount++; if (irqId !== 4'd2) begin failCount++; $display("[TB] FAIL wrap_ptr0: got %0d expected 2", irqId); end
  endtask

  task automatic test_mask();
    doReset();
    writeMask(11'h004);
    req = 11'h020;
    step();
    checkCount++; if (pend !== 11'h020) begin failCount++; $display("[TB] FAIL mask_pend: got %h expected 020", pend); end
    checkCount++; if (anyP !== 1'b0) begin failCount++; $display("[TB] FAIL mask_any_off: got %0b expected 0", anyP); end
    step();
    checkCount++; if (irq !== 1'b0) begin failCount++; $display("[TB] FAIL mask_irq_off: got %0b expected 0", irq); end
    writeMask(11'h020);
    checkCount++; if (anyP !== 1'b1) begin failCount++; $display("[TB] FAIL mask_any_on: got %0b expected 1", anyP); end
    step();
    checkCount++; if (irq !== 1'b1) begin failCount++; $display("[TB] FAIL mask_irq_on: got %0b expected 1", irq); end
    checkCount++; if (irqId !== 4'd6) begin failCount++; $display("[TB] FAIL mask_id: got %0d expected 6", irqId); end
    ack = 1'b1; step(); ack = 1'b0;
    step();
    checkCount++; if (pend !== 11'h000) begin failCount++; $display("[TB] FAIL mask_level_hold: got %h expected 000", pend); end
    // Ack and Eoi outside their states are ignored: stay in SERVICE with id 6.
    ack = 1'b1; step(); ack = 1'b0;
    checkCount++; if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL mask_stray_ack: got %0b expected 1", busy); end
    writeMask(11'h000);
    checkCount++; if (irqId !== 4'd6) begin failCount++; $display("[TB] FAIL mask_svc_write: got %0d expected 6", irqId); end
    req = 11'h000;
  endtask

  task automatic test_disable_in_req();
    doReset();
    writeMask(11'h7FF);
    req = 11'h002; step(); req = 11'h000; step();
    checkCount++; if (irqId !== 4'd2) begin failCount++; $display("[TB] FAIL dis_id: got %0d expected 2", irqId); end
    writeMask(11'h000);
    checkCount++; if (irq !== 1'b0) begin failCount++; $display("[TB] FAIL dis_irq: got %0b expected 0", irq); end
    checkCount++; if (irqId !== 4'd0) begin failCount++; $display("[TB] FAIL dis_id0: got %0d expected 0", irqId); end
    checkCount++; if (pend !== 11'h002) begin failCount++; $display("[TB] FAIL dis_pend: got %h expected 002", pend); end
    doReset();
    writeMask(11'h7FF);
    req = 11'h002; step(); req = 11'h000; step();
    cfgWe = 1'b1; cfgData = 11'h000; ack = 1'b1; eoi = 1'b1;
    step();
    cfgWe = 1'b0; ack = 1'b0; eoi = 1'b0;
    checkCount++; if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL ackwr_busy: got %0b expected 1", busy); end
    checkCount++; if (irqId !== 4'd2) begin failCount++; $display("[TB] FAIL ackwr_id: got %0d expected 2", irqId); end
    step();
    checkCount++; if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL ackeoi_busy: got %0b expected 1", busy); end
  endtask

  task automatic test_back_to_back();
    doReset();
    writeMask(11'h7FF);
    req = 11'h004; step(); req = 11'h000; step();
    checkCount++; if (irqId !== 4'd3) begin failCount++; $display("[TB] FAIL b2b_id: got %0d expected 3", irqId); end
    ack = 1'b1; req = 11'h004;
    step();
    ack = 1'b0; req = 11'h000;
    checkCount++; if (pend !== 11'h004) begin failCount++; $display("[TB] FAIL b2b_setwins: got %h expected 004", pend); end
    eoi = 1'b1; step(); eoi = 1'b0;
    checkCount++; if (irqId !== 4'd0) begin failCount++; $display("[TB] FAIL b2b_eoi: got %0d expected 0", irqId); end
    step();
    checkCount++; if (irqId !== 4'd3) begin failCount++; $display("[TB] FAIL b2b_regrant: got %0d expected 3", irqId); end
  endtask

  task automatic test_invert_reset();
    reqInv = 11'h001;
    doReset();
    writeMask(11'h7FF);
    checkCount++; if (pendI !== 11'h000) begin failCount++; $display("[TB] FAIL inv_idle: got %h expected 000", pendI); end
    reqInv = 11'h000;
    step();
    checkCount++; if (pendI !== 11'h001) begin failCount++; $display("[TB] FAIL inv_fall: got %h expected 001", pendI); end
    step();
    checkCount++; if (irqIdI !== 4'd1) begin failCount++; $display("[TB] FAIL inv_id: got %0d expected 1", irqIdI); end
    ack = 1'b1; step(); ack = 1'b0;
    checkCount++; if (busyI !== 1'b1) begin failCount++; $display("[TB] FAIL inv_busy: got %0b expected 1", busyI); end
    #2 reset = 1'b1;
    #1;
    checkCount++; if (busyI !== 1'b0) begin failCount++; $display("[TB] FAIL async_busy: got %0b expected 0", busyI); end
    checkCount++; if (irqIdI !== 4'd0) begin failCount++; $display("[TB] FAIL async_id: got %0d expected 0", irqIdI); end
    checkCount++; if (pendI !== 11'h000) begin failCount++; $display("[TB] FAIL async_pend: got %h expected 000", pendI); end
    step();
    reset = 1'b0;
    // reqInv[0] held low looks like a high level, so the first clock sees an edge.
    step();
    checkCount++; if (pendI !== 11'h001) begin failCount++; $display("[TB] FAIL inv_first_edge: got %h expected 001", pendI); end
    checkCount++; if (anyPI !== 1'b0) begin failCount++; $display("[TB] FAIL inv_enable_clr: got %0b expected 0", anyPI); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_mask();
    test_disable_in_req();
    test_back_to_back();
    test_invert_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
